// File: rtl/tamagotchi_input_conditioner_if.sv
// ---------------------------------------------------------------------------
// tamagotchi_input_conditioner_if
// Bundle between the board pins and the input conditioner.
//   master : board / stimulus side, drives the raw asynchronous levels and
//            observes the conditioned outputs.
//   slave  : conditioner side, receives raw levels and drives the outputs.
// Signals:
//   btn_a_raw, btn_b_raw, btn_c_raw, btn_test_raw, btn_speed_raw : raw buttons
//   luz_raw      : raw light sensor (0 = light, 1 = dark)
//   A, B, C      : one-cycle press pulses
//   test         : long-press-toggled test level
//   time_control : 2-bit speed select
//   luz          : debounced light level
// ---------------------------------------------------------------------------
interface tamagotchi_input_conditioner_if;
   logic       btn_a_raw;
   logic       btn_b_raw;
   logic       btn_c_raw;
   logic       btn_test_raw;
   logic       btn_speed_raw;
   logic       luz_raw;
   logic       A;
   logic       B;
   logic       C;
   logic       test;
   logic [1:0] time_control;
   logic       luz;

   modport master (
      output btn_a_raw, btn_b_raw, btn_c_raw, btn_test_raw, btn_speed_raw, luz_raw,
      input  A, B, C, test, time_control, luz
   );

   modport slave (
      input  btn_a_raw, btn_b_raw, btn_c_raw, btn_test_raw, btn_speed_raw, luz_raw,
      output A, B, C, test, time_control, luz
   );
endinterface

// File: rtl/tamagotchi_input_conditioner.sv
// ---------------------------------------------------------------------------
// tamagotchi_input_conditioner
// Front-end for the pet state machine: synchronizes and debounces the raw
// buttons and light sensor so one physical press gives exactly one event.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low reset (0 = reset)
//   bus   : slave side of tamagotchi_input_conditioner_if
//           (raw inputs in; A/B/C pulses, test, time_control, luz out)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module tamagotchi_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned LONG_CYCLES     = 250000000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1,
   parameter int unsigned CNT_W           = 28
) (
   input logic                           clk,
   input logic                           reset,
   tamagotchi_input_conditioner_if.slave bus
);
   // Channel order: 0 = A, 1 = B, 2 = C, 3 = test, 4 = speed, 5 = luz.
   localparam int unsigned NCH = 6;
   // Raw level of each channel when idle; XOR with it normalizes to pressed=1.
   localparam logic [NCH-1:0]   IDLE_RAW = {1'b0, {5{BTN_ACTIVE_LOW}}};
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);

   logic [NCH-1:0]   w_raw;
   logic [NCH-1:0]   w_lvl;
   logic [3:0]       w_rise;      // {speed, C, B, A} debounced 0->1
   logic [NCH-1:0]   r_sync1;
   logic [NCH-1:0]   r_sync2;
   logic [NCH-1:0]   r_deb;
   logic [3:0]       r_deb_q;     // previous debounced {speed, C, B, A}
   logic [CNT_W-1:0] r_cnt [NCH];
   logic [CNT_W-1:0] r_hold;
   logic [2:0]       r_pulse;
   logic             r_test;
   logic [1:0]       r_tc;

   assign w_raw  = {bus.luz_raw, bus.btn_speed_raw, bus.btn_test_raw,
                    bus.btn_c_raw, bus.btn_b_raw, bus.btn_a_raw};
   assign w_lvl  = r_sync2 ^ IDLE_RAW;
   assign w_rise = {r_deb[4], r_deb[2:0]} & ~r_deb_q;

   // Synchronizers and debouncers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1 <= IDLE_RAW;
         r_sync2 <= IDLE_RAW;
         r_deb   <= '0;
         for (int unsigned i = 0; i < NCH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         for (int unsigned i = 0; i < NCH; i++) begin
            if (w_lvl[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == DEB_LAST) begin
               // DEBOUNCE_CYCLES-th consecutive differing cycle: accept.
               r_deb[i] <= w_lvl[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Press pulses, speed select and test long-press.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_deb_q <= '0;
         r_pulse <= '0;
         r_tc    <= '0;
         r_hold  <= '0;
         r_test  <= 1'b0;
      end else begin
         r_deb_q <= {r_deb[4], r_deb[2:0]};
         r_pulse <= w_rise[2:0];
         if (w_rise[3]) begin
            r_tc <= r_tc + 2'd1;
         end
         // Hold counter saturates at LONG_CYCLES so test flips only once
         // per hold; a debounced release re-arms it.
         if (r_deb[3]) begin
            if (r_hold != LONG_MAX) begin
               r_hold <= r_hold + CNT_W'(1);
               if (r_hold == LONG_MAX - CNT_W'(1)) begin
                  r_test <= ~r_test;
               end
            end
         end else begin
            r_hold <= '0;
         end
      end
   end

   assign bus.A            = r_pulse[0];
   assign bus.B            = r_pulse[1];
   assign bus.C            = r_pulse[2];
   assign bus.test         = r_test;
   assign bus.time_control = r_tc;
   assign bus.luz          = r_deb[5];
endmodule
